// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scroll driver: blank pattern, hex glyph table
// and the message entry layout.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int unsigned ENTRY_W = 5;

  typedef struct packed {
    logic       dp;
    logic [3:0] ch;
  } entry_t;

  // {a,b,c,d,e,f,g}, active-low; index 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex character to active-low seven-segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] ch,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_GLYPHS[ch];
  end

endmodule

// File: rtl/seg7_scroll_driver.sv
// Multiplexed N-digit seven-segment driver with a writable message buffer,
// frame-synchronous scrolling and blanked dead time at the start of each digit slot.
module seg7_scroll_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned MSG_LEN     = 16,
  parameter int unsigned REFRESH_DIV = 2000,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned SCROLL_DIV  = 2**20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       scroll_en,
  input  logic                       step,
  input  logic                       blank,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [3:0]                 wr_data,
  input  logic                       wr_dp,
  output logic [DIGITS-1:0]          an,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic                       frame_tick,
  output logic                       wrap_tick
);

  localparam int unsigned AW  = $clog2(MSG_LEN);
  localparam int unsigned DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SLW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [SLW-1:0] SLOT_LAST   = SLW'(REFRESH_DIV - 1);
  localparam logic [SLW-1:0] SLOT_DEAD   = SLW'(DEAD_CYCLES);
  localparam logic [DW-1:0]  DIGIT_LAST  = DW'(DIGITS - 1);
  localparam logic [SW-1:0]  SCROLL_LAST = SW'(SCROLL_DIV - 1);
  localparam logic [AW-1:0]  BASE_LAST   = AW'(MSG_LEN - 1);
  localparam logic [AW:0]    MSG_LEN_W   = (AW + 1)'(MSG_LEN);

  logic [SLW-1:0]     slot_q, slot_d;
  logic [DW-1:0]      digit_q, digit_d;
  logic [AW-1:0]      base_q, base_d;
  logic [SW-1:0]      scroll_q, scroll_d;
  logic               pending_q, pending_d;
  logic               wrap_q, wrap_d;
  logic [ENTRY_W-1:0] mem_q [MSG_LEN];
  logic [DIGITS-1:0]  an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic               slot_last, frame_end, req, advance, dead_d;
  logic [DW-1:0]      offset;
  logic [AW:0]        addr_sum;
  logic [AW-1:0]      rd_addr;
  entry_t             rd_entry;
  logic [6:0]         rd_glyph;

  // Counters, scroll requests and base pointer.
  always_comb begin
    slot_last = (slot_q == SLOT_LAST);
    frame_end = slot_last && (digit_q == '0);
    req       = step || (scroll_en && (scroll_q == SCROLL_LAST));
    advance   = frame_end && (pending_q || req);

    slot_d  = slot_last ? '0 : slot_q + 1'b1;
    digit_d = digit_q;
    if (slot_last) begin
      digit_d = (digit_q == '0) ? DIGIT_LAST : digit_q - 1'b1;
    end

    scroll_d = '0;
    if (scroll_en) begin
      scroll_d = (scroll_q == SCROLL_LAST) ? '0 : scroll_q + 1'b1;
    end

    pending_d = advance ? 1'b0 : (pending_q || req);
    base_d    = base_q;
    if (advance) begin
      base_d = (base_q == BASE_LAST) ? '0 : base_q + 1'b1;
    end
    wrap_d = advance && (base_q == BASE_LAST);
  end

  // Address of the entry shown in the upcoming slot; base + offset < 2*MSG_LEN always.
  always_comb begin
    offset   = DIGIT_LAST - digit_d;
    addr_sum = {1'b0, base_d} + (AW + 1)'(offset);
    if (addr_sum >= MSG_LEN_W) begin
      addr_sum = addr_sum - MSG_LEN_W;
    end
    rd_addr  = addr_sum[AW-1:0];
    rd_entry = entry_t'(mem_q[rd_addr]);
  end

  seg7_decoder u_decoder (
    .ch  (rd_entry.ch),
    .seg (rd_glyph)
  );

  // Glyph is latched once at the start of the active phase and held for the whole slot.
  always_comb begin
    dead_d = (slot_d < SLOT_DEAD);
    an_d   = '1;
    if (!blank && !dead_d) begin
      an_d[digit_d] = 1'b0;
    end
    seg_d = seg_q;
    dp_d  = dp_q;
    if (dead_d) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end else if (slot_d == SLOT_DEAD) begin
      seg_d = rd_glyph;
      dp_d  = ~rd_entry.dp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q    <= '0;
      digit_q   <= DIGIT_LAST;
      base_q    <= '0;
      scroll_q  <= '0;
      pending_q <= 1'b0;
      wrap_q    <= 1'b0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      slot_q    <= slot_d;
      digit_q   <= digit_d;
      base_q    <= base_d;
      scroll_q  <= scroll_d;
      pending_q <= pending_d;
      wrap_q    <= wrap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= {wr_dp, wr_data};
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_end;
  assign wrap_tick  = wrap_q;

endmodule
